// File: rtl/fft32_mdc_sequencer.sv
// Frame sequencer for a 32-point radix-2 MDC FFT (2 lanes, 16 pairs/frame, 5 stages).
// Each accepted sample pair pushes a 1 into a valid shift chain. Stage enables and
// output strobes are registered taps on that chain, so timing follows the data
// rather than a free-running counter. Frames may follow each other with no bubble.
//
// Handshake: in_valid has no backpressure. Every in_valid cycle outside ERR is
// either accepted (in order, in_sop on the first pair only) or flagged as a
// protocol error. in_sop is only meaningful while in_valid is high.
module fft32_mdc_sequencer #(
  parameter int BF_LAT = 1,
  parameter int DLY0   = 8,
  parameter int DLY1   = 4,
  parameter int DLY2   = 2,
  parameter int DLY3   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       clear_err,
  output logic [4:0] stage_en,
  output logic [4:0] com_sel,
  output logic [3:0] rom16_addr,
  output logic [2:0] rom8_addr,
  output logic [1:0] rom4_addr,
  output logic       out_valid,
  output logic       out_sop,
  output logic       frame_done,
  output logic       busy,
  output logic       err
);

  // Cycles from acceptance of a pair to the moment it enters each stage.
  localparam int OFF0    = DLY0;
  localparam int OFF1    = OFF0 + BF_LAT + DLY1;
  localparam int OFF2    = OFF1 + BF_LAT + DLY2;
  localparam int OFF3    = OFF2 + BF_LAT + DLY3;
  localparam int OFF4    = OFF3 + BF_LAT;
  localparam int OUT_LAT = OFF4 + BF_LAT;
  // The output registers supply the final cycle of delay, so the chain is one short.
  localparam int CW      = OUT_LAT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   chain;
  logic [OUT_LAT-1:0] taps;
  logic [3:0]      in_idx;
  logic [3:0]      out_cnt;
  // Stage counters keep only the bits that are observed; the low bits of a
  // mod-16 counter are themselves a mod-2^k counter, so behaviour is unchanged.
  logic [3:0]      c0;
  logic [2:0]      c1;
  logic [1:0]      c2;
  logic            c3;
  logic            acc;
  logic            err_det;
  logic            sop_err;
  logic            nosop_err;
  logic            gap_err;

  // taps[k] is high when a pair was accepted k cycles ago (taps[0] = this cycle).
  assign taps = {chain, acc};

  // Protocol checks; an accepted pair is any legal in_valid cycle outside ERR.
  always_comb begin
    sop_err   = in_valid && in_sop && (in_idx != 4'd0);
    nosop_err = in_valid && !in_sop && (in_idx == 4'd0);
    gap_err   = (state == RUN) && !in_valid && (in_idx != 4'd0);
    err_det   = (state != ERR) && (sop_err || nosop_err || gap_err);
    acc       = (state != ERR) && in_valid && !err_det;
  end

  // Next-state logic; an error overrides every other transition.
  always_comb begin
    state_n = state;
    if (err_det) begin
      state_n = ERR;
    end else begin
      case (state)
        IDLE:    if (acc) state_n = RUN;
        // in_idx has wrapped to 0: a new SOP keeps RUN, silence starts draining.
        RUN:     if ((in_idx == 4'd0) && !in_valid) state_n = DRAIN;
        DRAIN:   if (acc) state_n = RUN;
                 else if (chain == '0) state_n = IDLE;
        ERR:     if (clear_err) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Valid chain, stage/output strobes and counters; an error flushes them all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= '0;
      stage_en  <= '0;
      out_valid <= 1'b0;
      in_idx    <= '0;
      out_cnt   <= '0;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= 1'b0;
      err       <= 1'b0;
    end else if (err_det) begin
      chain     <= '0;
      stage_en  <= '0;
      out_valid <= 1'b0;
      in_idx    <= '0;
      out_cnt   <= '0;
      c0        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= 1'b0;
      err       <= 1'b1;
    end else begin
      chain     <= taps[CW-1:0];
      stage_en  <= {taps[OFF4-1], taps[OFF3-1], taps[OFF2-1], taps[OFF1-1], taps[OFF0-1]};
      out_valid <= taps[OUT_LAT-1];
      if (acc)         in_idx  <= in_idx + 4'd1;
      if (out_valid)   out_cnt <= out_cnt + 4'd1;
      if (stage_en[0]) c0      <= c0 + 4'd1;
      if (stage_en[1]) c1      <= c1 + 3'd1;
      if (stage_en[2]) c2      <= c2 + 2'd1;
      if (stage_en[3]) c3      <= ~c3;
      if ((state == ERR) && clear_err) err <= 1'b0;
    end
  end

  // Commutator selects toggle every 8, 4, 2, 1 valid cycles; the last stage has none.
  assign com_sel    = {1'b0, c3, c2[1], c1[2], c0[3]};
  assign rom16_addr = stage_en[0] ? c0 : 4'd0;
  assign rom8_addr  = stage_en[1] ? c1 : 3'd0;
  assign rom4_addr  = stage_en[2] ? c2 : 2'd0;
  assign out_sop    = out_valid && (out_cnt == 4'd0);
  // An error in the same cycle as the last output pair cancels the completion pulse.
  assign frame_done = out_valid && (out_cnt == 4'd15) && !err_det;
  assign busy       = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_fft32_mdc_sequencer.sv
// Bench for fft32_mdc_sequencer: one default instance and one with BF_LAT=2,
// driven by the same randomized frame/error stimulus.
module tb_fft32_mdc_sequencer;

  localparam int W = 34;  // {cycle[31:0], sop, done}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       clear_err = 1'b0;

  logic [4:0] stage_en, com_sel;
  logic [3:0] rom16_addr;
  logic [2:0] rom8_addr;
  logic [1:0] rom4_addr;
  logic       out_valid, out_sop, frame_done, busy, err;

  logic [4:0] stage_en_b, com_sel_b;
  logic [3:0] rom16_addr_b;
  logic [2:0] rom8_addr_b;
  logic [1:0] rom4_addr_b;
  logic       out_valid_b, out_sop_b, frame_done_b, busy_b, err_b;

  fft32_mdc_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .clear_err(clear_err),
    .stage_en(stage_en), .com_sel(com_sel), .rom16_addr(rom16_addr), .rom8_addr(rom8_addr),
    .rom4_addr(rom4_addr), .out_valid(out_valid), .out_sop(out_sop), .frame_done(frame_done),
    .busy(busy), .err(err)
  );

  fft32_mdc_sequencer #(.BF_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .clear_err(clear_err),
    .stage_en(stage_en_b), .com_sel(com_sel_b), .rom16_addr(rom16_addr_b), .rom8_addr(rom8_addr_b),
    .rom4_addr(rom4_addr_b), .out_valid(out_valid_b), .out_sop(out_sop_b), .frame_done(frame_done_b),
    .busy(busy_b), .err(err_b)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  int            off_a[5];
  int            off_b[5];
  int            lat_a, lat_b;
  logic [W-1:0]  exp_q[$];          // output pairs of instance A, in order
  int            stg_a[longint];    // key cycle*8+stage -> pair position in frame
  int            stg_b[longint];
  logic [2:0]    outb[int];         // instance B: cycle -> {valid, sop, done}
  int            m_pos;             // position of the next pair in the frame
  bit            m_err;
  bit            err_now, busy_a_now, busy_b_now;
  int            bu_a, bu_b;        // last cycle a frame is still in flight
  int            n_chk = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;

  // Stage offset from the delay-line depths and butterfly latency.
  function automatic int spec_off(input int bf, input int s);
    int dly[5];
    int o;
    dly = '{8, 4, 2, 1, 0};
    o = dly[0];
    for (int k = 1; k <= s; k++) o = o + bf + dly[k];
    return o;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    stg_a.delete();
    stg_b.delete();
    outb.delete();
    m_pos = 0; m_err = 1'b0; err_now = 1'b0;
    busy_a_now = 1'b0; busy_b_now = 1'b0;
    bu_a = -1; bu_b = -1;
  endtask

  // Drop everything scheduled after cycle c; a completion due at c is cancelled.
  task automatic flush(input int c);
    logic [W-1:0] keep[$];
    longint       ks[$];
    int           kb[$];
    foreach (exp_q[i]) begin
      if (int'(exp_q[i][W-1:2]) < c) keep.push_back(exp_q[i]);
      else if (int'(exp_q[i][W-1:2]) == c) keep.push_back({exp_q[i][W-1:1], 1'b0});
    end
    exp_q = keep;
    foreach (stg_a[k]) if (k / 8 > longint'(c)) ks.push_back(k);
    foreach (ks[i]) stg_a.delete(ks[i]);
    ks.delete();
    foreach (stg_b[k]) if (k / 8 > longint'(c)) ks.push_back(k);
    foreach (ks[i]) stg_b.delete(ks[i]);
    foreach (outb[k]) begin
      if (k > c) kb.push_back(k);
      else if (k == c) outb[k][0] = 1'b0;
    end
    foreach (kb[i]) outb.delete(kb[i]);
  endtask

  // Apply the frame protocol to this cycle's inputs and schedule the responses.
  task automatic model_cycle(input bit v, input bit s, input bit clr);
    int  c;
    bit  bad;
    c = cyc;
    err_now    = m_err;
    busy_a_now = (c <= bu_a);
    busy_b_now = (c <= bu_b);
    if (m_err) begin
      if (clr) m_err = 1'b0;
    end else begin
      bad = (v && s && m_pos != 0) || (v && !s && m_pos == 0) || (!v && m_pos != 0);
      if (bad) begin
        flush(c);
        m_err = 1'b1; m_pos = 0; bu_a = -1; bu_b = -1;
      end else if (v) begin
        for (int st = 0; st < 5; st++) begin
          stg_a[longint'(c + off_a[st]) * 8 + longint'(st)] = m_pos;
          stg_b[longint'(c + off_b[st]) * 8 + longint'(st)] = m_pos;
        end
        exp_q.push_back({32'(c + lat_a), (m_pos == 0), (m_pos == 15)});
        outb[c + lat_b] = {1'b1, (m_pos == 0), (m_pos == 15)};
        bu_a = c + lat_a;
        bu_b = c + lat_b;
        m_pos = (m_pos + 1) % 16;
      end
    end
  endtask

  // Expected {stage_en, com_sel, rom16, rom8, rom4} for one instance at cycle c.
  function automatic logic [18:0] exp_stage(input int c, input bit use_b);
    logic [4:0] se, cs;
    logic [3:0] r16;
    logic [2:0] r8;
    logic [1:0] r4;
    longint     key;
    int         j;
    bit         hit;
    se = '0; cs = '0; r16 = '0; r8 = '0; r4 = '0;
    for (int s = 0; s < 5; s++) begin
      key = longint'(c) * 8 + longint'(s);
      hit = 1'b0; j = 0;
      if (use_b) begin
        if (stg_b.exists(key)) begin hit = 1'b1; j = stg_b[key]; end
      end else begin
        if (stg_a.exists(key)) begin hit = 1'b1; j = stg_a[key]; end
      end
      if (hit) begin
        se[s] = 1'b1;
        if (s < 4) cs[s] = ((j >> (3 - s)) & 1) != 0;
        if (s == 0) r16 = 4'(j);
        if (s == 1) r8 = 3'(j % 8);
        if (s == 2) r4 = 2'(j % 4);
      end
    end
    return {se, cs, r16, r8, r4};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit s, input bit clr);
    in_valid = v; in_sop = s; clear_err = clr;
    model_cycle(v, s, clr);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic partial(input int k);
    for (int j = 0; j < k; j++) drive(1'b1, j == 0, 1'b0);
  endtask

  task automatic recover();
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    drive(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stage_en"}, stage_en, 0);   chk({tag, "_com_sel"}, com_sel, 0);
    chk({tag, "_rom16"}, rom16_addr, 0);    chk({tag, "_rom8"}, rom8_addr, 0);
    chk({tag, "_rom4"}, rom4_addr, 0);      chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sop"}, out_sop, 0);     chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);           chk({tag, "_err"}, err, 0);
    chk({tag, "_b_stage_en"}, stage_en_b, 0); chk({tag, "_b_out_valid"}, out_valid_b, 0);
    chk({tag, "_b_busy"}, busy_b, 0);       chk({tag, "_b_err"}, err_b, 0);
  endtask

  task automatic async_reset();
    in_valid = 1'b0; in_sop = 1'b0; clear_err = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [18:0]  ea;
    logic [18:0]  eb;
    logic [W-1:0] e;
    logic [2:0]   ob;
    if (mon_en && rst_n) begin
      ea = exp_stage(cyc, 1'b0);
      chk("stage_en", stage_en, ea[18:14]);
      chk("com_sel", com_sel, ea[13:9]);
      chk("rom16_addr", rom16_addr, ea[8:5]);
      chk("rom8_addr", rom8_addr, ea[4:2]);
      chk("rom4_addr", rom4_addr, ea[1:0]);
      chk("busy", busy, busy_a_now);
      chk("err", err, err_now);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", cyc, e[W-1:2]);
          chk("out_sop", out_sop, e[1]);
          chk("frame_done", frame_done, e[0]);
        end
      end else begin
        chk("out_sop_idle", out_sop, 0);
        chk("frame_done_idle", frame_done, 0);
        if (exp_q.size() > 0 && int'(exp_q[0][W-1:2]) <= cyc) begin
          e = exp_q.pop_front();
          chk("out_missing", out_valid, 1);
        end
      end
      eb = exp_stage(cyc, 1'b1);
      ob = 3'b000;
      if (outb.exists(cyc)) ob = outb[cyc];
      chk("b_stage_en", stage_en_b, eb[18:14]);
      chk("b_com_sel", com_sel_b, eb[13:9]);
      chk("b_rom16_addr", rom16_addr_b, eb[8:5]);
      chk("b_rom8_addr", rom8_addr_b, eb[4:2]);
      chk("b_rom4_addr", rom4_addr_b, eb[1:0]);
      chk("b_out_valid", out_valid_b, ob[2]);
      chk("b_out_sop", out_sop_b, ob[1]);
      chk("b_frame_done", frame_done_b, ob[0]);
      chk("b_busy", busy_b, busy_b_now);
      chk("b_err", err_b, err_now);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    for (int s = 0; s < 5; s++) begin
      off_a[s] = spec_off(1, s);
      off_b[s] = spec_off(2, s);
    end
    lat_a = off_a[4] + 1;
    lat_b = off_b[4] + 2;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single frame, then drain to idle.
    partial(16); idle(25);
    // Two frames back to back.
    partial(16); partial(16); idle(25);
    // A gap lands on the cycle the previous frame's last output appears.
    partial(16); idle(4); partial(15); drive(1'b0, 1'b0, 1'b0);
    idle(3); drive(1'b0, 1'b0, 1'b1); idle(2);
    // Misplaced SOP mid-frame.
    partial(5); drive(1'b1, 1'b1, 1'b0); idle(2); drive(1'b1, 1'b1, 1'b1); idle(2);
    // Valid without SOP from idle.
    drive(1'b1, 1'b0, 1'b0); idle(12); drive(1'b0, 1'b0, 1'b1);
    partial(16); idle(25);

    // Randomized mix of clean frames, idles and protocol errors.
    for (int it = 0; it < 45; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: partial(16);
        2:    idle($urandom_range(1, 22));
        3:    begin partial($urandom_range(1, 15)); drive(1'b0, 1'b0, 1'b0); recover(); end
        4:    begin partial($urandom_range(1, 15)); drive(1'b1, 1'b1, 1'b0); recover(); end
        default: begin drive(1'b1, 1'b0, 1'b0); recover(); end
      endcase
    end
    idle(25);

    // Asynchronous reset in the middle of a frame, then a clean frame.
    partial(10);
    async_reset();
    partial(16); idle(30);

    mon_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
